// File: rtl/freq_mode_stream.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : freq_mode_stream                                                 |
// | Purpose  : Streaming frame histogram / mode finder. Collects FRAME_LEN      |
// |            samples into one counter per value, scans the bins one per cycle |
// |            for the most frequent value (lowest value wins ties) and holds   |
// |            the result until the consumer takes it.                          |
// | Ports    : clk, rst (async, active-high), clr (sync frame abort)            |
// |            in_valid/in_ready/in_data   - sample input handshake             |
// |            out_valid/out_ready         - result handshake                   |
// |            out_mode, out_count         - winning value and its count        |
// |            out_hist                    - packed per-bin counts, only when   |
// |                                          FREQ_MODE_HIST_OUT_EN is defined   |
// | Macro    : FREQ_MODE_HIST_OUT_EN - exports the histogram on out_hist        |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module freq_mode_stream #(
   parameter  int DW        = 2,
   parameter  int FRAME_LEN = 8,
   localparam int NB        = 1 << DW,
   localparam int CW        = $clog2(FRAME_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_mode,
   output logic [CW-1:0] out_count
`ifdef FREQ_MODE_HIST_OUT_EN
   ,
   output logic [NB*CW-1:0] out_hist
`endif
);

   localparam logic [CW-1:0] c_LAST    = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
   localparam logic [DW:0]   c_IDX_END = (DW + 1)'(NB);
   localparam logic [DW:0]   c_IDX_ONE = (DW + 1)'(1);

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_hist [NB];
   logic [CW-1:0] r_cnt;
   logic [DW:0]   r_idx;        // one extra bit: value NB marks "scan finished"
   logic [CW-1:0] r_max;
   logic [DW-1:0] r_max_idx;
   logic          r_in_ready;
   logic          r_out_valid;
   logic [DW-1:0] r_out_mode;
   logic [CW-1:0] r_out_count;
   logic          w_accept;

   assign w_accept  = in_valid && r_in_ready && (r_state == ST_ACCUM);
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_mode  = r_out_mode;
   assign out_count = r_out_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_ACCUM;
         for (int i = 0; i < NB; i++) r_hist[i] <= '0;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_max       <= '0;
         r_max_idx   <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_mode  <= '0;
         r_out_count <= '0;
      end else if (clr) begin
         // Abort has priority over any accept or result handshake this cycle.
         r_state     <= ST_ACCUM;
         for (int i = 0; i < NB; i++) r_hist[i] <= '0;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_max       <= '0;
         r_max_idx   <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_mode  <= '0;
         r_out_count <= '0;
      end else begin
         case (r_state)
            ST_ACCUM: begin
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  r_hist[in_data] <= r_hist[in_data] + c_CNT_ONE;
                  if (r_cnt == c_LAST) begin
                     r_cnt      <= '0;
                     r_idx      <= '0;
                     r_in_ready <= 1'b0;
                     r_state    <= ST_SCAN;
                  end else begin
                     r_cnt <= r_cnt + c_CNT_ONE;
                  end
               end
            end
            ST_SCAN: begin
               // NB compare cycles, then one commit cycle that publishes the
               // winner, giving out_valid NB+1 edges after the last accept.
               if (r_idx == c_IDX_END) begin
                  r_out_mode  <= r_max_idx;
                  r_out_count <= r_max;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  // Strict compare keeps the earliest (lowest) value on ties.
                  if (r_hist[r_idx[DW-1:0]] > r_max) begin
                     r_max     <= r_hist[r_idx[DW-1:0]];
                     r_max_idx <= r_idx[DW-1:0];
                  end
                  r_idx <= r_idx + c_IDX_ONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  for (int i = 0; i < NB; i++) r_hist[i] <= '0;
                  r_idx       <= '0;
                  r_max       <= '0;
                  r_max_idx   <= '0;
                  r_out_valid <= 1'b0;
                  r_out_mode  <= '0;
                  r_out_count <= '0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_ACCUM;
               end
            end
            default: begin
               r_state <= ST_ACCUM;
            end
         endcase
      end
   end

`ifdef FREQ_MODE_HIST_OUT_EN
   // Bins stay frozen throughout DONE, so they read directly as the frame histogram.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_hist
         assign out_hist[gi*CW +: CW] = r_hist[gi];
      end
   endgenerate
`endif

endmodule
`default_nettype wire
